mul_ctrl_fsm: RTL and testbench

//  Sequencing controller for the 8-bit shift-and-add multiplier datapath.

---
 rtl/mul_pkg.sv | 19 +
 rtl/mul_bit_counter.sv | 31 +++
 rtl/mul_ctrl_fsm.sv | 95 +++++++++
 tb/tb_mul_ctrl_fsm.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the shift-and-add multiplier controller.
package mul_pkg;

  // Operand width, which is also the number of add/shift iterations.
  localparam int DATA_WIDTH = 8;

  // Iteration counter width, derived from DATA_WIDTH.
  localparam int CNT_WIDTH = $clog2(DATA_WIDTH) + 1;

  // Controller states; the encodings are fixed so external tools can decode them.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    ITER   = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/mul_bit_counter.sv
// Iteration counter: counts enabled cycles, saturates at DATA_WIDTH-1.
module mul_bit_counter
  import mul_pkg::*;
#(
  parameter int DW = DATA_WIDTH
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic clr,
  input  logic en,
  output logic terminal
);

  localparam int CW = $clog2(DW) + 1;
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  logic [CW-1:0] cnt;

  // Counter register: sync reset/clear, advance when enabled, hold at the last step.
  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments on every clocked register so all flops update together at the edge.
    if (i_rst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign terminal = (cnt == LAST);

endmodule

// File: rtl/mul_ctrl_fsm.sv
// Sequencing controller for the 8-bit shift-and-add multiplier datapath.
module mul_ctrl_fsm
  import mul_pkg::*;
#(
  parameter int DW = DATA_WIDTH
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic start,
  input  logic A_out,
  output logic ready,
  output logic busy,
  output logic load_A,
  output logic load_B,
  output logic clr_ACC_reg,
  output logic load_ACC,
  output logic sel_SUM,
  output logic shift_A_reg,
  output logic done
);

  state_t state;
  state_t state_next;
  logic   cnt_terminal;

  // Iteration counter: cleared while loading B, advanced once per ITER cycle.
  mul_bit_counter #(
    .DW(DW)
  ) u_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .clr     (state == LOAD_B),
    .en      (state == ITER),
    .terminal(cnt_terminal)
  );

  // State register with synchronous reset that aborts any operation in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and Moore output decode; sel_SUM follows A_out during ITER.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_next  = state;
    ready       = 1'b0;
    busy        = 1'b1;
    load_A      = 1'b0;
    load_B      = 1'b0;
    clr_ACC_reg = 1'b0;
    load_ACC    = 1'b0;
    sel_SUM     = 1'b0;
    shift_A_reg = 1'b0;
    done        = 1'b0;

    unique case (state)
      IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
        if (start) begin
          state_next = LOAD_A;
        end
      end
      LOAD_A: begin
        load_A      = 1'b1;
        clr_ACC_reg = 1'b1;
        state_next  = LOAD_B;
      end
      LOAD_B: begin
        load_B     = 1'b1;
        state_next = ITER;
      end
      ITER: begin
        load_ACC    = 1'b1;
        shift_A_reg = 1'b1;
        sel_SUM     = A_out;
        if (cnt_terminal) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mul_ctrl_fsm.sv
// Testbench for mul_ctrl_fsm with a behavioural shift-and-add datapath model.
module tb_mul_ctrl_fsm;

  logic i_clk = 1'b0;
  logic i_rst;
  logic start;
  logic A_out;
  logic ready, busy, load_A, load_B, clr_ACC_reg, load_ACC, sel_SUM, shift_A_reg, done;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 i_clk = ~i_clk;

  mul_ctrl_fsm dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .start      (start),
    .A_out      (A_out),
    .ready      (ready),
    .busy       (busy),
    .load_A     (load_A),
    .load_B     (load_B),
    .clr_ACC_reg(clr_ACC_reg),
    .load_ACC   (load_ACC),
    .sel_SUM    (sel_SUM),
    .shift_A_reg(shift_A_reg),
    .done       (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Datapath model: operands come from the bench, registers react to the strobes.
  logic [7:0] op_a, op_b;
  logic [7:0] a_m, b_m, acc_m;
  logic [8:0] sum_m;
  logic [7:0] data_in;

  assign data_in = load_A ? op_a : op_b;
  assign A_out   = a_m[0];
  assign sum_m   = {1'b0, acc_m} + {1'b0, b_m};

  always @(posedge i_clk) begin
    if (load_A) a_m <= data_in;
    if (load_B) b_m <= data_in;
    if (clr_ACC_reg) acc_m <= 8'h00;
    if (load_ACC && shift_A_reg) begin
      if (sel_SUM) begin
        acc_m <= sum_m[8:1];
        a_m   <= {sum_m[0], a_m[7:1]};
      end else begin
        acc_m <= {1'b0, acc_m[7:1]};
        a_m   <= {acc_m[0], a_m[7:1]};
      end
    end
  end

  // Per-cycle invariants, sampled on the falling edge once reset has been applied.
  logic mon_en    = 1'b0;
  logic prev_iter = 1'b0;
  always @(negedge i_clk) begin
    if (mon_en) begin
      check("onehot0_loads", 32'($countones({load_A, load_B, load_ACC}) <= 1), 32'd1);
      check("busy_not_ready", 32'(busy), 32'(!ready));
      if (done) check("done_after_iter", 32'(prev_iter), 32'd1);
      prev_iter = load_ACC;
    end
  end

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] product;
    logic [7:0]  sel_pat;
    int          latency;
  } vec_t;

  vec_t vecs[6];

  // Run one multiply; results observed #1 after each rising edge.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output int latency, output logic [7:0] sel_pat,
                        output int n_acc, output logic [15:0] product);
    int cyc;
    op_a = a;
    op_b = b;
    latency = -1;
    sel_pat = 8'h00;
    n_acc = 0;
    product = 16'hxxxx;
    @(negedge i_clk);
    start = 1'b1;
    @(posedge i_clk);
    #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 40) begin
      if (load_ACC) begin
        if (n_acc < 8) sel_pat[n_acc] = sel_SUM;
        n_acc++;
      end
      if (done) begin
        latency = cyc;
        product = {acc_m, a_m};
        break;
      end
      @(posedge i_clk);
      #1;
      cyc++;
    end
    @(negedge i_clk);
  endtask

  initial begin
    int lat, nacc, dcount, t1, t2;
    logic [7:0]  pat;
    logic [15:0] prod;

    vecs[0] = '{8'd13,  8'd11,  16'h008F, 8'h0D, 11};
    vecs[1] = '{8'd255, 8'd255, 16'hFE01, 8'hFF, 11};
    vecs[2] = '{8'd0,   8'd200, 16'h0000, 8'h00, 11};
    vecs[3] = '{8'd1,   8'd1,   16'h0001, 8'h01, 11};
    vecs[4] = '{8'd128, 8'd3,   16'h0180, 8'h80, 11};
    vecs[5] = '{8'd170, 8'd85,  16'h3872, 8'hAA, 11};

    i_rst = 1'b1;
    start = 1'b0;
    op_a  = 8'h00;
    op_b  = 8'h00;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    mon_en = 1'b1;

    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_strobes", 32'({load_A, load_B, clr_ACC_reg, load_ACC, sel_SUM, shift_A_reg, done}), 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, lat, pat, nacc, prod);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].latency));
      check($sformatf("v%0d_product", i), 32'(prod), 32'(vecs[i].product));
      check($sformatf("v%0d_sel_pat", i), 32'(pat), 32'(vecs[i].sel_pat));
      check($sformatf("v%0d_load_acc_cycles", i), 32'(nacc), 32'd8);
    end

    // Reset mid-ITER: back to IDLE at once, no done pulse afterwards.
    op_a = 8'd13;
    op_b = 8'd11;
    @(negedge i_clk);
    start = 1'b1;
    @(posedge i_clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge i_clk);
    #1;
    check("pre_rst_in_iter", 32'(load_ACC), 32'd1);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    check("rst_mid_ready", 32'(ready), 32'd1);
    check("rst_mid_strobes", 32'({load_A, load_B, clr_ACC_reg, load_ACC, sel_SUM, shift_A_reg, done}), 32'd0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    dcount = 0;
    for (int c = 0; c < 15; c++) begin
      if (done) dcount++;
      @(posedge i_clk);
      #1;
    end
    check("rst_no_done", 32'(dcount), 32'd0);
    check("rst_idle_after", 32'(ready), 32'd1);

    // start pulsed during ITER is ignored: exactly one done.
    @(negedge i_clk);
    start = 1'b1;
    @(posedge i_clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge i_clk);
    #1;
    start = 1'b1;
    @(posedge i_clk);
    #1;
    start = 1'b0;
    dcount = 0;
    for (int c = 0; c < 30; c++) begin
      if (done) dcount++;
      @(posedge i_clk);
      #1;
    end
    check("iter_start_one_done", 32'(dcount), 32'd1);

    // start held high: back-to-back operations, done pulses 12 cycles apart.
    @(negedge i_clk);
    start = 1'b1;
    t1 = -1;
    t2 = -1;
    for (int c = 0; c < 60; c++) begin
      @(posedge i_clk);
      #1;
      if (done) begin
        if (t1 < 0) t1 = c;
        else if (t2 < 0) t2 = c;
      end
      if (t2 >= 0) break;
    end
    start = 1'b0;
    check("held_first_done", 32'(t1), 32'd10);
    check("held_done_spacing", 32'(t2 - t1), 32'd12);
    repeat (3) @(posedge i_clk);
    #1;
    check("final_idle", 32'(ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
